// File: rtl/ixu_iq_gen_pkg.sv
// Shared types and constants for the ixu integer issue queue (package ixu_pkg).
// Entry payload fields are sized to the widest supported tag/ROB id. Narrower configs zero-extend.
package ixu_pkg;

  localparam int unsigned IQ_TAG_W_MAX = 16;
  localparam int unsigned IQ_ROB_W_MAX = 16;

  // Bit positions inside the per-uop restrict field.
  localparam int unsigned RST_A_IDX = 1;
  localparam int unsigned RST_B_IDX = 0;

  typedef struct packed {
    logic                    vld;
    logic [IQ_TAG_W_MAX-1:0] rs1;
    logic [IQ_TAG_W_MAX-1:0] rs2;
    logic [IQ_ROB_W_MAX-1:0] rob;
    logic                    rdy1;
    logic                    rdy2;
    logic                    rstA;
    logic                    rstB;
  } iq_entry_t;

  function automatic int unsigned IQ_DATA_W(input int unsigned tag_w, input int unsigned rob_w);
    return 2 * tag_w + rob_w;
  endfunction

endpackage

// File: rtl/ixu_iq_gen_pick.sv
// Lowest-index one-hot picker with enable. o_any reports that a grant was made.
module ixu_iq_pick #(
  parameter int unsigned DEPTH = 10
) (
  input  logic             i_en,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_gnt,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_en && i_req[i] && !o_any) begin
        o_gnt[i] = 1'b1;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ixu_iq_gen.sv
// Age-ordered collapsing dual-issue integer issue queue (entry 0 oldest).
// Optional perf counters are enabled by defining IXU_IQ_PERF_EN.
module ixu_iq_gen
  import ixu_pkg::*;
#(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 6,
  parameter int unsigned NWK   = 3,
  localparam int unsigned DW    = IQ_DATA_W(TAG_W, ROB_W),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 core_clock_i,
  input  logic                 core_reset_i,
  input  logic                 core_flush_i,
  input  logic                 p0_vld_i,
  input  logic                 p1_vld_i,
  input  logic [DW-1:0]        p0_data_i,
  input  logic [DW-1:0]        p1_data_i,
  input  logic [1:0]           p0_rs_vld_i,
  input  logic [1:0]           p1_rs_vld_i,
  input  logic [1:0]           p0_rs_rdy_i,
  input  logic [1:0]           p1_rs_rdy_i,
  input  logic [1:0]           p0_rst_i,
  input  logic [1:0]           p1_rst_i,
  output logic                 p0_busy_o,
  output logic                 p1_busy_o,
  output logic [CNT_W-1:0]     free_cnt_o,
  input  logic [NWK-1:0]       wk_vld_i,
  input  logic [NWK*TAG_W-1:0] wk_tag_i,
  input  logic                 a_busy_i,
  input  logic                 b_busy_i,
  output logic                 a_vld_o,
  output logic                 b_vld_o,
  output logic [DW-1:0]        a_data_o,
  output logic [DW-1:0]        b_data_o
`ifdef IXU_IQ_PERF_EN
  ,
  output logic [31:0]          perf_issue_o,
  output logic [31:0]          perf_full_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  iq_entry_t        r_q   [DEPTH];
  iq_entry_t        w_nxt [DEPTH];
  iq_entry_t        w_new0, w_new1;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DEPTH-1:0] w_rdy1, w_rdy2, w_rdy, w_req_a, w_req_b, w_gnt_a, w_gnt_b, w_issued;
  logic             w_any_a, w_any_b, w_acc0, w_acc1;
  logic [DW-1:0]    w_a_data, w_b_data;

  function automatic logic wk_hit(input logic [IQ_TAG_W_MAX-1:0] tag,
                                  input logic [NWK-1:0] v,
                                  input logic [NWK*TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NWK; k++) begin
      if (v[k] && (IQ_TAG_W_MAX'(t[k*TAG_W +: TAG_W]) == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic iq_entry_t mk_entry(input logic [DW-1:0] d,
                                         input logic [1:0] rs_vld,
                                         input logic [1:0] rs_rdy,
                                         input logic [1:0] rst,
                                         input logic [NWK-1:0] v,
                                         input logic [NWK*TAG_W-1:0] t);
    iq_entry_t e;
    e      = '0;
    e.vld  = 1'b1;
    e.rs1  = IQ_TAG_W_MAX'(d[ROB_W+TAG_W +: TAG_W]);
    e.rs2  = IQ_TAG_W_MAX'(d[ROB_W +: TAG_W]);
    e.rob  = IQ_ROB_W_MAX'(d[ROB_W-1:0]);
    e.rdy1 = !rs_vld[1] | rs_rdy[1] | wk_hit(e.rs1, v, t);
    e.rdy2 = !rs_vld[0] | rs_rdy[0] | wk_hit(e.rs2, v, t);
    e.rstA = rst[RST_A_IDX];
    e.rstB = rst[RST_B_IDX];
    return e;
  endfunction

  assign p0_busy_o = (r_cnt == CNT_W'(DEPTH));
  assign p1_busy_o = (r_cnt >= CNT_W'(DEPTH - 1));
  assign w_acc0    = p0_vld_i & !p0_busy_o & !core_flush_i;
  assign w_acc1    = p1_vld_i & !p1_busy_o & !core_flush_i;
  assign w_new0    = mk_entry(p0_data_i, p0_rs_vld_i, p0_rs_rdy_i, p0_rst_i, wk_vld_i, wk_tag_i);
  assign w_new1    = mk_entry(p1_data_i, p1_rs_vld_i, p1_rs_rdy_i, p1_rst_i, wk_vld_i, wk_tag_i);

  // Same-cycle wakeup feeds select directly.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_rdy1[i]  = r_q[i].rdy1 | wk_hit(r_q[i].rs1, wk_vld_i, wk_tag_i);
      w_rdy2[i]  = r_q[i].rdy2 | wk_hit(r_q[i].rs2, wk_vld_i, wk_tag_i);
      w_rdy[i]   = r_q[i].vld & w_rdy1[i] & w_rdy2[i];
      w_req_a[i] = w_rdy[i] & !r_q[i].rstA;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_req_b[i] = w_rdy[i] & !r_q[i].rstB & !w_gnt_a[i];
    end
  end

  ixu_iq_pick #(.DEPTH(DEPTH)) u_pick_a (
    .i_en  (!a_busy_i && !core_flush_i),
    .i_req (w_req_a),
    .o_gnt (w_gnt_a),
    .o_any (w_any_a)
  );

  ixu_iq_pick #(.DEPTH(DEPTH)) u_pick_b (
    .i_en  (!b_busy_i && !core_flush_i),
    .i_req (w_req_b),
    .o_gnt (w_gnt_b),
    .o_any (w_any_b)
  );

  assign w_issued = w_gnt_a | w_gnt_b;

  always_comb begin
    w_a_data = '0;
    w_b_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_gnt_a[i]) w_a_data = {r_q[i].rs2[TAG_W-1:0], r_q[i].rs1[TAG_W-1:0], r_q[i].rob[ROB_W-1:0]};
      if (w_gnt_b[i]) w_b_data = {r_q[i].rs2[TAG_W-1:0], r_q[i].rs1[TAG_W-1:0], r_q[i].rob[ROB_W-1:0]};
    end
  end

  // Survivors pack down in age order, then accepted dispatches stack on top (p0 below p1).
  always_comb begin
    logic [CNT_W-1:0] v_pos;
    v_pos = '0;
    for (int unsigned i = 0; i < DEPTH; i++) w_nxt[i] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_q[i].vld && !w_issued[i]) begin
        if (v_pos < CNT_W'(DEPTH)) begin
          w_nxt[v_pos[IDX_W-1:0]]      = r_q[i];
          w_nxt[v_pos[IDX_W-1:0]].rdy1 = w_rdy1[i];
          w_nxt[v_pos[IDX_W-1:0]].rdy2 = w_rdy2[i];
        end
        v_pos = v_pos + 1'b1;
      end
    end
    if (w_acc0) begin
      if (v_pos < CNT_W'(DEPTH)) w_nxt[v_pos[IDX_W-1:0]] = w_new0;
      v_pos = v_pos + 1'b1;
    end
    if (w_acc1 && (v_pos < CNT_W'(DEPTH))) w_nxt[v_pos[IDX_W-1:0]] = w_new1;
  end

  assign w_cnt_nxt = r_cnt - CNT_W'(w_any_a) - CNT_W'(w_any_b) + CNT_W'(w_acc0) + CNT_W'(w_acc1);

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i || core_flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i].vld <= 1'b0;
      r_cnt      <= '0;
      free_cnt_o <= CNT_W'(DEPTH);
      a_vld_o    <= 1'b0;
      b_vld_o    <= 1'b0;
      if (core_reset_i) begin
        a_data_o <= '0;
        b_data_o <= '0;
      end
    end else begin
      r_q        <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      free_cnt_o <= CNT_W'(DEPTH) - w_cnt_nxt;
      a_vld_o    <= w_any_a;
      b_vld_o    <= w_any_b;
      if (w_any_a) a_data_o <= w_a_data;
      if (w_any_b) b_data_o <= w_b_data;
    end
  end

`ifdef IXU_IQ_PERF_EN
  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      perf_issue_o <= '0;
      perf_full_o  <= '0;
    end else begin
      perf_issue_o <= perf_issue_o + 32'(w_any_a) + 32'(w_any_b);
      if (p0_vld_i && p0_busy_o) perf_full_o <= perf_full_o + 32'd1;
    end
  end
`endif

  // A uop excluded from both pipes could never leave the queue.
  p0_rst_legal: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
    w_acc0 |-> (p0_rst_i != 2'b11));
  p1_rst_legal: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
    w_acc1 |-> (p1_rst_i != 2'b11));

endmodule

// File: tb/tb_ixu_iq_gen.sv
// Directed table-driven bench for ixu_iq_gen (DEPTH=10, TAG_W=6, ROB_W=6, NWK=3).
module tb_ixu_iq_gen;

  localparam int unsigned DW = 18;

  logic          clk = 1'b0;
  logic          core_reset_i = 1'b0, core_flush_i = 1'b0;
  logic          p0_vld_i = 1'b0, p1_vld_i = 1'b0;
  logic [DW-1:0] p0_data_i = '0, p1_data_i = '0;
  logic [1:0]    p0_rs_vld_i = '0, p1_rs_vld_i = '0, p0_rs_rdy_i = '0, p1_rs_rdy_i = '0;
  logic [1:0]    p0_rst_i = '0, p1_rst_i = '0;
  logic          p0_busy_o, p1_busy_o;
  logic [3:0]    free_cnt_o;
  logic [2:0]    wk_vld_i = '0;
  logic [17:0]   wk_tag_i = '0;
  logic          a_busy_i = 1'b0, b_busy_i = 1'b0;
  logic          a_vld_o, b_vld_o;
  logic [DW-1:0] a_data_o, b_data_o;
`ifdef IXU_IQ_PERF_EN
  logic [31:0]   perf_issue_o, perf_full_o;
`endif

  always #5 clk = ~clk;

  ixu_iq_gen #(.DEPTH(10), .TAG_W(6), .ROB_W(6), .NWK(3)) dut (
    .core_clock_i(clk), .core_reset_i(core_reset_i), .core_flush_i(core_flush_i),
    .p0_vld_i(p0_vld_i), .p1_vld_i(p1_vld_i), .p0_data_i(p0_data_i), .p1_data_i(p1_data_i),
    .p0_rs_vld_i(p0_rs_vld_i), .p1_rs_vld_i(p1_rs_vld_i),
    .p0_rs_rdy_i(p0_rs_rdy_i), .p1_rs_rdy_i(p1_rs_rdy_i),
    .p0_rst_i(p0_rst_i), .p1_rst_i(p1_rst_i),
    .p0_busy_o(p0_busy_o), .p1_busy_o(p1_busy_o), .free_cnt_o(free_cnt_o),
    .wk_vld_i(wk_vld_i), .wk_tag_i(wk_tag_i), .a_busy_i(a_busy_i), .b_busy_i(b_busy_i),
    .a_vld_o(a_vld_o), .b_vld_o(b_vld_o), .a_data_o(a_data_o), .b_data_o(b_data_o)
`ifdef IXU_IQ_PERF_EN
    , .perf_issue_o(perf_issue_o), .perf_full_o(perf_full_o)
`endif
  );

  typedef struct {
    bit rst, fl; bit [1:0] pv;
    bit [17:0] d0; bit [1:0] rv0, rr0, rs0;
    bit [17:0] d1; bit [1:0] rv1, rr1, rs1;
    bit [2:0] wv; bit [17:0] wt; bit ab, bb;
    bit ea; bit [17:0] ead; bit eb; bit [17:0] ebd; bit e0b, e1b; bit [3:0] efc;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0, n_err = 0;

  function automatic bit [17:0] pk(input int x, input int y, input int z);
    return {x[5:0], y[5:0], z[5:0]};
  endfunction

  function automatic vec_t V(input bit rst, fl, input bit [1:0] pv,
      input bit [17:0] d0, input bit [1:0] rv0, rr0, rs0,
      input bit [17:0] d1, input bit [1:0] rv1, rr1, rs1,
      input bit [2:0] wv, input bit [17:0] wt, input bit ab, bb,
      input bit ea, input bit [17:0] ead, input bit eb, input bit [17:0] ebd,
      input bit e0b, e1b, input bit [3:0] efc);
    vec_t v;
    v = '{rst, fl, pv, d0, rv0, rr0, rs0, d1, rv1, rr1, rs1, wv, wt, ab, bb,
          ea, ead, eb, ebd, e0b, e1b, efc};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    core_reset_i = v.rst; core_flush_i = v.fl;
    p0_vld_i = v.pv[0]; p1_vld_i = v.pv[1];
    p0_data_i = v.d0; p0_rs_vld_i = v.rv0; p0_rs_rdy_i = v.rr0; p0_rst_i = v.rs0;
    p1_data_i = v.d1; p1_rs_vld_i = v.rv1; p1_rs_rdy_i = v.rr1; p1_rst_i = v.rs1;
    wk_vld_i = v.wv; wk_tag_i = v.wt; a_busy_i = v.ab; b_busy_i = v.bb;
    @(posedge clk); #1;
  endtask

  // Idle cycle with given pipe back-pressure; outputs are sampled #1 after the edge.
  task automatic idle(input bit ab, input bit bb);
    apply(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, ab,bb, 0,0,0,0, 0,0,0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    // Reset, then dispatch with two wakeups on successive cycles (port 1 tag 7 invalid on first).
    tv.push_back(V(1,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    tv.push_back(V(0,0,2'b01, pk(5,7,1),2'b11,2'b00,2'b00, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,9));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b001,pk(0,7,5), 0,0, 0,0,0,0, 0,0,9));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b010,pk(0,7,0), 0,0, 1,pk(7,5,1),0,0, 0,0,10));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    // Dual issue, then A back-pressure routes oldest to B.
    tv.push_back(V(0,0,2'b11, pk(1,2,10),2'b00,2'b00,2'b00, pk(3,4,11),2'b11,2'b11,2'b00, 3'b000,0, 0,0, 0,0,0,0, 0,0,8));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 1,pk(2,1,10),1,pk(4,3,11), 0,0,10));
    tv.push_back(V(0,0,2'b11, pk(8,9,12),0,0,0, pk(10,11,13),0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,8));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 1,0, 0,0,1,pk(9,8,12), 0,0,9));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 1,pk(11,10,13),0,0, 0,0,10));
    // Dispatch-cycle wakeup of rs1 (rs2 unused).
    tv.push_back(V(0,0,2'b01, pk(20,21,14),2'b10,2'b00,2'b00, 0,0,0,0, 3'b100,pk(20,0,0), 0,0, 0,0,0,0, 0,0,9));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 1,pk(21,20,14),0,0, 0,0,10));
    // Restrict bits: older excluded from A, then older excluded from B under mixed back-pressure.
    tv.push_back(V(0,0,2'b11, pk(30,31,15),0,0,2'b10, pk(32,33,16),0,0,2'b00, 3'b000,0, 0,0, 0,0,0,0, 0,0,8));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 1,pk(33,32,16),1,pk(31,30,15), 0,0,10));
    tv.push_back(V(0,0,2'b11, pk(40,41,17),0,0,2'b01, pk(42,43,18),0,0,2'b00, 3'b000,0, 0,0, 0,0,0,0, 0,0,8));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 1,0, 0,0,1,pk(43,42,18), 0,0,9));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,1, 1,pk(41,40,17),0,0, 0,0,10));
    // Fill with unready uops (rob 20..29), then full-queue behaviour.
    for (int k = 0; k < 4; k++)
      tv.push_back(V(0,0,2'b11, pk(50,51,20+2*k),2'b11,0,0, pk(50,51,21+2*k),2'b11,0,0, 3'b000,0, 0,0,
                     0,0,0,0, 0,0, 4'(8-2*k)));
    tv.push_back(V(0,0,2'b01, pk(50,51,28),2'b11,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,1,1));
    tv.push_back(V(0,0,2'b11, pk(50,51,29),2'b11,0,0, pk(50,51,30),2'b11,0,0, 3'b000,0, 0,0, 0,0,0,0, 1,1,0));
    tv.push_back(V(0,0,2'b01, pk(60,61,40),0,0,0, 0,0,0,0, 3'b011,pk(0,51,50), 0,0,
                   1,pk(51,50,20),1,pk(51,50,21), 0,0,2));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 1,pk(51,50,22),1,pk(51,50,23), 0,0,4));
    // Flush with 6 resident entries plus a ready dispatch.
    tv.push_back(V(0,1,2'b01, pk(1,1,41),0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    // Reset together with flush over a ready entry.
    tv.push_back(V(0,0,2'b01, pk(2,2,42),0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,9));
    tv.push_back(V(1,1,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    tv.push_back(V(0,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));

    foreach (tv[i]) begin
      apply(tv[i]);
      chk($sformatf("row%0d a_vld", i), a_vld_o, tv[i].ea);
      chk($sformatf("row%0d b_vld", i), b_vld_o, tv[i].eb);
      if (tv[i].ea) chk($sformatf("row%0d a_data", i), a_data_o, tv[i].ead);
      if (tv[i].eb) chk($sformatf("row%0d b_data", i), b_data_o, tv[i].ebd);
      chk($sformatf("row%0d p0_busy", i), p0_busy_o, tv[i].e0b);
      chk($sformatf("row%0d p1_busy", i), p1_busy_o, tv[i].e1b);
      chk($sformatf("row%0d free_cnt", i), free_cnt_o, tv[i].efc);
    end

    // Ready uop held by back-pressure on both pipes; output data holds its post-reset value.
    apply(V(0,0,2'b01, pk(3,4,50),0,0,0, 0,0,0,0, 3'b000,0, 1,1, 0,0,0,0, 0,0,0));
    chk("hold dispatch free_cnt", free_cnt_o, 9);
    for (int c = 0; c < 3; c++) begin
      idle(1, 1);
      chk($sformatf("hold%0d vld", c), {a_vld_o, b_vld_o}, 2'b00);
      chk($sformatf("hold%0d free_cnt", c), free_cnt_o, 9);
    end
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      idle(1, 0);
      if (b_vld_o) found = 1'b1;
    end
    chk("hold wait b_vld", found, 1);
    chk("hold b_data", b_data_o, pk(4, 3, 50));
    chk("hold a_vld", a_vld_o, 0);
    chk("hold a_data", a_data_o, 0);
    idle(0, 0);
    chk("hold final free_cnt", free_cnt_o, 10);

`ifdef IXU_IQ_PERF_EN
    apply(V(1,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    chk("perf reset issue", perf_issue_o, 0);
    chk("perf reset full", perf_full_o, 0);
    for (int c = 0; c < 3; c++)
      apply(V(0,0,2'b11, pk(1,1,60+2*c),0,0,0, pk(1,1,61+2*c),0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,0));
    chk("perf mid issue", perf_issue_o, 4);
    idle(0, 0);
    chk("perf issue", perf_issue_o, 6);
    idle(0, 0);
    chk("perf issue stable", perf_issue_o, 6);
    apply(V(1,0,2'b00, 0,0,0,0, 0,0,0,0, 3'b000,0, 0,0, 0,0,0,0, 0,0,10));
    chk("perf issue cleared", perf_issue_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
